// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Mid-bit sample positions relative to OVERSAMPLE/2. The vote resolves on
  // the last of the three samples, so MID_HI_OFS marks the decision tick.
  localparam int MID_LO_OFS = -1;
  localparam int MID_HI_OFS = 1;

  // Majority of three samples.
  function automatic logic MAJ3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchroniser, falling-edge detector and 3-sample majority voter.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  output logic rx_sync,
  output logic rx_fall,
  output logic vote
);

  // Older samples kept alongside the live one to form the 3-way vote.
  localparam int HIST = MID_HI_OFS - MID_LO_OFS;

  logic            rx_meta_reg;
  logic            rx_sync_reg;
  logic            rx_prev_reg;
  logic [HIST-1:0] samp_reg;

  // Two-flop synchroniser, one-cycle delay for edge detect, tick-enabled history.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      samp_reg    <= '1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      if (baud_tick) samp_reg <= {samp_reg[HIST-2:0], rx_sync_reg};
    end
  end

  assign rx_sync = rx_sync_reg;
  assign rx_fall = rx_prev_reg & ~rx_sync_reg;
  // Two stored samples plus the one being taken on this tick.
  assign vote    = MAJ3({samp_reg, rx_sync_reg});

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-voted sampling and ready/valid output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int             TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 + MID_HI_OFS);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           PAR_ON    = (PARITY_EN != 0);
  localparam logic           ODD       = (PARITY_ODD != 0);

  logic rx_sync, rx_fall, vote;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_sync   (rx_sync),
    .rx_fall   (rx_fall),
    .vote      (vote)
  );

  rx_state_t            state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_next;
  logic [3:0]           bit_cnt_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bad_reg, par_bad_next;
  logic                 frm_bad_reg, frm_bad_next;
  logic                 deliver;
  logic                 mid_tick;

  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 overrun_reg, overrun_next;

  // The decision tick: the third of the three mid-bit samples.
  assign mid_tick = baud_tick && (tick_cnt_reg == TICK_MID);

  // Frame FSM: bit timing, shifting and error accumulation.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_cnt_reg;
    bit_next     = bit_cnt_reg;
    shift_next   = shift_reg;
    par_bad_next = par_bad_reg;
    frm_bad_next = frm_bad_reg;
    deliver      = 1'b0;
    if (baud_tick) tick_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        if (rx_fall) begin
          state_next   = START;
          bit_next     = '0;
          par_bad_next = 1'b0;
          frm_bad_next = 1'b0;
        end
      end
      START: if (mid_tick) state_next = vote ? IDLE : DATA;
      DATA: if (mid_tick) begin
        shift_next = {vote, shift_reg[DATA_BITS-1:1]};
        if (bit_cnt_reg == DATA_LAST) begin
          bit_next   = '0;
          state_next = PAR_ON ? PARITY : STOP;
        end else begin
          bit_next = bit_cnt_reg + 4'd1;
        end
      end
      PARITY: if (mid_tick) begin
        par_bad_next = (^shift_reg) ^ vote ^ ODD;
        state_next   = STOP;
      end
      STOP: if (mid_tick) begin
        frm_bad_next = frm_bad_reg | ~vote;
        if (bit_cnt_reg == STOP_LAST) begin
          deliver    = 1'b1;
          bit_next   = '0;
          state_next = frm_bad_next ? WAIT_IDLE : IDLE;
        end else begin
          bit_next = bit_cnt_reg + 4'd1;
        end
      end
      // A break or stuck-low line must return high before a new start is armed.
      WAIT_IDLE: if (rx_sync) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_bad_reg  <= 1'b0;
      frm_bad_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_next;
      bit_cnt_reg  <= bit_next;
      shift_reg    <= shift_next;
      par_bad_reg  <= par_bad_next;
      frm_bad_reg  <= frm_bad_next;
    end
  end

  // Output holding register: load when free or being drained, else drop and flag overrun.
  always_comb begin
    data_next       = data_reg;
    frame_err_next  = frame_err_reg;
    parity_err_next = parity_err_reg;
    valid_next      = valid_reg & ~ready;
    overrun_next    = (valid_reg & ready) ? 1'b0 : overrun_reg;
    if (deliver) begin
      if (!valid_reg || ready) begin
        data_next       = shift_reg;
        frame_err_next  = frm_bad_next;
        parity_err_next = par_bad_reg;
        valid_next      = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign data       = data_reg;
  assign valid      = valid_reg;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three configurations driven from a vector table
// plus hand-written sequences; received words are checked against a scoreboard.
module tb_uart_rx_param;

  localparam int TDIV     = 4;               // clk cycles per baud_tick
  localparam int OS       = 16;
  localparam int BIT_CLKS = OS * TDIV;

  logic clk, rst, baud_tick;
  logic [2:0] rxl, rdy;

  logic [7:0] data0, data1;
  logic [8:0] data2;
  logic valid0, valid1, valid2, fe0, fe1, fe2, pe0, pe1, pe2;
  logic ov0, ov1, ov2, busy0, busy1, busy2;

  logic [2:0] vld, fe_v, pe_v, ov_v, bsy;
  logic [8:0] dat [3];
  assign vld  = {valid2, valid1, valid0};
  assign fe_v = {fe2, fe1, fe0};
  assign pe_v = {pe2, pe1, pe0};
  assign ov_v = {ov2, ov1, ov0};
  assign bsy  = {busy2, busy1, busy0};
  assign dat[0] = {1'b0, data0};
  assign dat[1] = {1'b0, data1};
  assign dat[2] = data2;

  uart_rx_param u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rxl[0]), .data(data0), .valid(valid0),
    .ready(rdy[0]), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rxl[1]), .data(data1), .valid(valid1),
    .ready(rdy[1]), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1)
  );

  uart_rx_param #(.DATA_BITS(9), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rxl[2]), .data(data2), .valid(valid2),
    .ready(rdy[2]), .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(busy2)
  );

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    int         inst;
    logic [8:0] din;
    logic       par_bit;
    logic       stop_val;
    int         spike;     // frame bit index carrying a one-tick spike, -1 for none
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cyc [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (vld[k]) valid_cyc[k]++;
      if (vld[k] && rdy[k]) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word inst=%0d got data=%h fe=%0b pe=%0b, required no word",
                   k, dat[k], fe_v[k], pe_v[k]);
        end else begin
          e = sb.pop_front();
          if (e.inst != k || e.data != dat[k] || e.fe != fe_v[k] || e.pe != pe_v[k]) begin
            n_fail++;
            $display("FAIL word inst=%0d got data=%h fe=%0b pe=%0b, required inst=%0d data=%h fe=%0b pe=%0b",
                     k, dat[k], fe_v[k], pe_v[k], e.inst, e.data, e.fe, e.pe);
          end else begin
            $display("word inst=%0d data=%h fe=%0b pe=%0b ok", k, dat[k], fe_v[k], pe_v[k]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int inst, input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    e.inst = inst;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    sb.push_back(e);
  endtask

  task automatic clear_valid_cyc();
    for (int k = 0; k < 3; k++) valid_cyc[k] = 0;
  endtask

  // Drive one frame on the selected line; framing follows that instance's configuration.
  task automatic send_frame(input int inst, input logic [8:0] d, input logic par_bit,
                            input logic stop_val, input int spike);
    logic [15:0] fr;
    int n, nb;
    nb = (inst == 2) ? 9 : 8;
    fr = '1;
    n  = 0;
    fr[n] = 1'b0; n++;
    for (int b = 0; b < nb; b++) begin fr[n] = d[b]; n++; end
    if (inst == 1) begin fr[n] = par_bit; n++; end
    fr[n] = stop_val; n++;
    if (inst == 2) begin fr[n] = stop_val; n++; end
    for (int b = 0; b < n; b++) begin
      rxl[inst] = fr[b];
      if (b == spike) begin
        repeat (30) @(negedge clk);
        rxl[inst] = ~fr[b];
        repeat (TDIV) @(negedge clk);
        rxl[inst] = fr[b];
        repeat (BIT_CLKS - 30 - TDIV) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
  endtask

  // Bounded wait for all expected words to be consumed.
  task automatic wait_drain(input string name);
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    #2;
    chk(name, sb.size(), 0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, -1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h03C, 1'b0, 1'b1, -1, 9'h03C, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h003, 1'b1, 1'b1, -1, 9'h003, 1'b0, 1'b1};
    vecs[3] = '{1, 9'h003, 1'b0, 1'b1, -1, 9'h003, 1'b0, 1'b0};
    vecs[4] = '{1, 9'h080, 1'b1, 1'b1, -1, 9'h080, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h080, 1'b0, 1'b1, -1, 9'h080, 1'b0, 1'b1};
    vecs[6] = '{0, 9'h0A5, 1'b0, 1'b1,  2, 9'h0A5, 1'b0, 1'b0};
    vecs[7] = '{0, 9'h05A, 1'b0, 1'b1,  5, 9'h05A, 1'b0, 1'b0};
    vecs[8] = '{2, 9'h1FF, 1'b0, 1'b1, -1, 9'h1FF, 1'b0, 1'b0};
    vecs[9] = '{2, 9'h0A3, 1'b0, 1'b1, -1, 9'h0A3, 1'b0, 1'b0};

    rst = 1'b1;
    rxl = 3'b111;
    rdy = 3'b111;
    clear_valid_cyc();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", vld[k], 0);
      chk("rst_data", dat[k], 0);
      chk("rst_frame_err", fe_v[k], 0);
      chk("rst_parity_err", pe_v[k], 0);
      chk("rst_overrun", ov_v[k], 0);
      chk("rst_busy", bsy[k], 0);
    end

    // Vector table: one frame each, ready held high, single-cycle valid expected.
    for (int i = 0; i < 10; i++) begin
      clear_valid_cyc();
      push_exp(vecs[i].inst, vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe);
      send_frame(vecs[i].inst, vecs[i].din, vecs[i].par_bit, vecs[i].stop_val, vecs[i].spike);
      wait_drain("vec_drain");
      chk("vec_valid_cycles", valid_cyc[vecs[i].inst], 1);
    end

    // Framing error followed by a line held low for three frame times.
    clear_valid_cyc();
    push_exp(0, 9'h055, 1'b1, 1'b0);
    send_frame(0, 9'h055, 1'b0, 1'b0, -1);
    repeat (3 * 10 * BIT_CLKS) @(negedge clk);
    #1;
    chk("wait_idle_busy", busy0, 1);
    chk("wait_idle_valid_cycles", valid_cyc[0], 1);
    rxl[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("wait_idle_release_busy", busy0, 0);
    wait_drain("frame_err_drain");
    push_exp(0, 9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 1'b0, 1'b1, -1);
    wait_drain("recover_drain");

    // Overrun: second word dropped while the first is held.
    rdy[0] = 1'b0;
    push_exp(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 1'b0, 1'b1, -1);
    #1;
    chk("held_valid", valid0, 1);
    chk("held_data", data0, 8'h11);
    chk("held_overrun", ov0, 0);
    send_frame(0, 9'h022, 1'b0, 1'b1, -1);
    #1;
    chk("ovr_valid", valid0, 1);
    chk("ovr_data", data0, 8'h11);
    chk("ovr_overrun", ov0, 1);
    @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    #1;
    chk("ovr_hs_valid", valid0, 0);
    chk("ovr_hs_overrun", ov0, 0);
    rdy[0] = 1'b1;
    push_exp(0, 9'h033, 1'b0, 1'b0);
    send_frame(0, 9'h033, 1'b0, 1'b1, -1);
    wait_drain("ovr_drain");
    chk("ovr_after_overrun", ov0, 0);

    // Quarter-bit glitch on an idle line.
    clear_valid_cyc();
    @(negedge clk);
    rxl[0] = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("glitch_busy_rise", busy0, 1);
    repeat (8) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (48) @(negedge clk);
    #1;
    chk("glitch_busy_fall", busy0, 0);
    chk("glitch_valid_cycles", valid_cyc[0], 0);

    // Back-to-back 9-bit frames with two stop bits.
    clear_valid_cyc();
    push_exp(2, 9'h1FF, 1'b0, 1'b0);
    push_exp(2, 9'h000, 1'b0, 1'b0);
    send_frame(2, 9'h1FF, 1'b0, 1'b1, -1);
    send_frame(2, 9'h000, 1'b0, 1'b1, -1);
    wait_drain("b2b_drain");
    chk("b2b_valid_cycles", valid_cyc[2], 2);

    // Reset mid-frame: frame aborted, outputs cleared.
    clear_valid_cyc();
    rxl[2] = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    rst = 1'b1;
    rxl[2] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy2, 0);
    chk("midrst_valid", valid2, 0);
    chk("midrst_data0", data0, 0);
    chk("midrst_overrun", ov2, 0);
    repeat (12 * BIT_CLKS) @(negedge clk);
    #1;
    chk("midrst_valid_cycles", valid_cyc[2], 0);
    push_exp(2, 9'h155, 1'b0, 1'b0);
    send_frame(2, 9'h155, 1'b0, 1'b1, -1);
    wait_drain("midrst_recover_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
